// File: rtl/gtech_lsr_bank.sv
// gtech_lsr_bank: clocked multi-channel S/R flag bank with filtering.
// Optional input synchroniser enabled by defining GTECH_LSR_SYNC_EN.
module gtech_lsr_bank #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      PRIORITY = 0,
  parameter int unsigned      FILT     = 1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             ANY
);

  localparam int unsigned CW =
    (FILT < 1) ? 1 : $clog2(FILT + 1);
  localparam logic [CW-1:0] FMAX = CW'(FILT);

  if (PRIORITY > 2) begin : g_bad_pri
    $error("gtech_lsr_bank: PRIORITY must be 0, 1 or 2");
  end

  if (FILT < 1 || FILT > 15) begin : g_bad_filt
    $error("gtech_lsr_bank: FILT must be within 1..15");
  end

  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] r_in;

`ifdef GTECH_LSR_SYNC_EN
  logic [WIDTH-1:0] s_s1_q;
  logic [WIDTH-1:0] s_s2_q;
  logic [WIDTH-1:0] r_s1_q;
  logic [WIDTH-1:0] r_s2_q;

  // Two-flop synchroniser; resets to the inactive (high) level.
  always_ff @(posedge CP) begin
    if (RST) begin
      s_s1_q <= '1;
      s_s2_q <= '1;
      r_s1_q <= '1;
      r_s2_q <= '1;
    end else begin
      s_s1_q <= S;
      s_s2_q <= s_s1_q;
      r_s1_q <= R;
      r_s2_q <= r_s1_q;
    end
  end

  assign s_in = s_s2_q;
  assign r_in = r_s2_q;
`else
  assign s_in = S;
  assign r_in = R;
`endif

  logic [WIDTH-1:0][CW-1:0] s_cnt_q;
  logic [WIDTH-1:0][CW-1:0] s_cnt_d;
  logic [WIDTH-1:0][CW-1:0] r_cnt_q;
  logic [WIDTH-1:0][CW-1:0] r_cnt_d;
  logic [WIDTH-1:0]         s_qual;
  logic [WIDTH-1:0]         r_qual;

  // Low-run counters; a request qualifies when the
  // saturated next count reaches FILT (current sample low).
  always_comb begin
    s_cnt_d = '0;
    r_cnt_d = '0;
    s_qual  = '0;
    r_qual  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!s_in[i]) begin
        s_cnt_d[i] = (s_cnt_q[i] == FMAX) ?
          FMAX : s_cnt_q[i] + CW'(1);
      end
      if (!r_in[i]) begin
        r_cnt_d[i] = (r_cnt_q[i] == FMAX) ?
          FMAX : r_cnt_q[i] + CW'(1);
      end
      s_qual[i] = (s_cnt_d[i] == FMAX);
      r_qual[i] = (r_cnt_d[i] == FMAX);
    end
  end

  // Filter counters run independently of EN.
  always_ff @(posedge CP) begin
    if (RST) begin
      s_cnt_q <= '0;
      r_cnt_q <= '0;
    end else begin
      s_cnt_q <= s_cnt_d;
      r_cnt_q <= r_cnt_d;
    end
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Per-channel set/reset resolution.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s_qual[i], r_qual[i]})
        2'b10: q_d[i] = 1'b1;
        2'b01: q_d[i] = 1'b0;
        2'b11: begin
          if (PRIORITY == 1) begin
            q_d[i] = 1'b1;
          end else if (PRIORITY == 2) begin
            q_d[i] = ~q_q[i];
          end else begin
            q_d[i] = 1'b0;
          end
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // Flag state and edge pulses; disabled cycles drop requests.
  always_ff @(posedge CP) begin
    if (RST) begin
      q_q    <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else if (EN) begin
      q_q    <= q_d;
      rise_q <= q_d & ~q_q;
      fall_q <= ~q_d & q_q;
    end else begin
      rise_q <= '0;
      fall_q <= '0;
    end
  end

  assign Q    = q_q;
  assign QN   = ~q_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign ANY  = |q_q;

endmodule

// File: tb/tb_gtech_lsr_bank.sv
// tb_gtech_lsr_bank: three bank variants against a run-length model.
// Directed steps followed by randomized traffic.
module tb_gtech_lsr_bank;

  localparam int W  = 4;
  localparam int NI = 3;
  localparam logic [W-1:0] RV = 4'b1010;
  localparam int PRI [NI] = '{0, 1, 2};
  localparam int FLT [NI] = '{1, 3, 1};

  logic         cp = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] s;
  logic [W-1:0] r;

  logic [W-1:0] q    [NI];
  logic [W-1:0] qn   [NI];
  logic [W-1:0] rise [NI];
  logic [W-1:0] fall [NI];
  logic         any  [NI];

  logic [W-1:0] mq    [NI];
  logic [W-1:0] mrise [NI];
  logic [W-1:0] mfall [NI];
  int           runs  [NI][W];
  int           runr  [NI][W];
  logic [W-1:0] ds1 = '1;
  logic [W-1:0] ds2 = '1;
  logic [W-1:0] dr1 = '1;
  logic [W-1:0] dr2 = '1;

  int checks = 0;
  int errors = 0;

  always #5 cp = ~cp;

  gtech_lsr_bank #(
    .WIDTH(W), .PRIORITY(0), .FILT(1), .RST_VAL(RV)
  ) u0 (
    .CP(cp), .RST(rst), .EN(en), .S(s), .R(r),
    .Q(q[0]), .QN(qn[0]), .RISE(rise[0]),
    .FALL(fall[0]), .ANY(any[0])
  );

  gtech_lsr_bank #(
    .WIDTH(W), .PRIORITY(1), .FILT(3), .RST_VAL(RV)
  ) u1 (
    .CP(cp), .RST(rst), .EN(en), .S(s), .R(r),
    .Q(q[1]), .QN(qn[1]), .RISE(rise[1]),
    .FALL(fall[1]), .ANY(any[1])
  );

  gtech_lsr_bank #(
    .WIDTH(W), .PRIORITY(2), .FILT(1), .RST_VAL(RV)
  ) u2 (
    .CP(cp), .RST(rst), .EN(en), .S(s), .R(r),
    .Q(q[2]), .QN(qn[2]), .RISE(rise[2]),
    .FALL(fall[2]), .ANY(any[2])
  );

  task automatic chk(string tag, logic [W-1:0] obs,
                     logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("q%0d", k), q[k], mq[k]);
      chk($sformatf("qn%0d", k), qn[k], ~mq[k]);
      chk($sformatf("rise%0d", k), rise[k], mrise[k]);
      chk($sformatf("fall%0d", k), fall[k], mfall[k]);
      chk($sformatf("any%0d", k), {3'b000, any[k]},
          {3'b000, |mq[k]});
    end
  endtask

  // One clock edge: advance the model, then check all outputs.
  task automatic tick();
    logic [W-1:0] fs, fr, nq;
    bit sq, rq;
    @(posedge cp);
`ifdef GTECH_LSR_SYNC_EN
    fs = ds2;
    fr = dr2;
`else
    fs = s;
    fr = r;
`endif
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        mq[k] = RV;
        mrise[k] = '0;
        mfall[k] = '0;
        for (int i = 0; i < W; i++) begin
          runs[k][i] = 0;
          runr[k][i] = 0;
        end
      end
      ds1 = '1; ds2 = '1; dr1 = '1; dr2 = '1;
    end else begin
      for (int k = 0; k < NI; k++) begin
        nq = mq[k];
        for (int i = 0; i < W; i++) begin
          runs[k][i] = fs[i] ? 0 :
            (runs[k][i] < 64 ? runs[k][i] + 1 : 64);
          runr[k][i] = fr[i] ? 0 :
            (runr[k][i] < 64 ? runr[k][i] + 1 : 64);
          sq = (runs[k][i] >= FLT[k]);
          rq = (runr[k][i] >= FLT[k]);
          if (sq && rq) begin
            if (PRI[k] == 0) nq[i] = 1'b0;
            else if (PRI[k] == 1) nq[i] = 1'b1;
            else nq[i] = ~mq[k][i];
          end else if (sq) begin
            nq[i] = 1'b1;
          end else if (rq) begin
            nq[i] = 1'b0;
          end
        end
        if (en) begin
          mrise[k] = nq & ~mq[k];
          mfall[k] = ~nq & mq[k];
          mq[k] = nq;
        end else begin
          mrise[k] = '0;
          mfall[k] = '0;
        end
      end
      ds2 = ds1; dr2 = dr1;
      ds1 = s;   dr1 = r;
    end
    #1;
    check_all();
  endtask

  task automatic drive(logic rs, logic e, logic [W-1:0] sv,
                       logic [W-1:0] rv, int n);
    rst = rs;
    en  = e;
    s   = sv;
    r   = rv;
    repeat (n) tick();
  endtask

  initial begin
    logic [31:0]  rnd;
    logic [W-1:0] m;
    rst = 1'b1;
    en  = 1'b1;
    s   = '1;
    r   = '1;
    // Reset and reset-over-request.
    tick();
    chk("rst_q_const", q[0], 4'b1010);
    chk("rst_qn_const", qn[0], 4'b0101);
    drive(1'b1, 1'b1, 4'b0000, 4'b1111, 2);
    chk("rst_hold_const", q[1], 4'b1010);
    // Clear all channels.
    drive(1'b0, 1'b1, 4'b1111, 4'b0000, 5);
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 3);
    // Basic set then reset on channel 0.
    drive(1'b0, 1'b1, 4'b1110, 4'b1111, 1);
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 4);
    drive(1'b0, 1'b1, 4'b1111, 4'b1110, 1);
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 4);
    // Simultaneous set and reset.
    drive(1'b0, 1'b1, 4'b0000, 4'b0000, 6);
    drive(1'b0, 1'b1, 4'b1111, 4'b0000, 5);
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 3);
    // Filter: short pulse, glitch, full run.
    drive(1'b0, 1'b1, 4'b1110, 4'b1111, 2);
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 3);
    drive(1'b0, 1'b1, 4'b1110, 4'b1111, 1);
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1);
    drive(1'b0, 1'b1, 4'b1110, 4'b1111, 3);
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 3);
    // Enable low drops requests.
    drive(1'b0, 1'b1, 4'b1111, 4'b0000, 5);
    drive(1'b0, 1'b0, 4'b0000, 4'b1111, 2);
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 4);
    // Reset in the middle of a filter run.
    drive(1'b0, 1'b1, 4'b0101, 4'b1111, 2);
    drive(1'b1, 1'b1, 4'b0101, 4'b1111, 1);
    drive(1'b0, 1'b1, 4'b0101, 4'b1111, 5);
    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom();
      rst = (rnd[31:26] == 6'd0);
      en  = (rnd[25:23] != 3'd0);
      m   = rnd[3:0] & rnd[11:8];
      s   = (s & ~m) | (rnd[7:4] & m);
      m   = rnd[15:12] & rnd[19:16];
      r   = (r & ~m) | (rnd[22:19] & m);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
